// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows stage: combinational row permutation on the
// input side, followed by a DEPTH-entry circular FIFO that carries the mode bit.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_inv,
  input  logic [0:32*NB-1]               b_shift,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_inv,
  output logic [0:32*NB-1]               a_shift,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int W  = 32 * NB;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("shift_rows_pipe: DEPTH must be at least 1");
  end

  // Rows 2 and 3 shift one extra column for the 256-bit block.
  function automatic int row_shift(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [0:W-1] fwd_perm;
  logic [0:W-1] inv_perm;
  logic [0:W-1] perm;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int FSRC = (c + row_shift(r)) % NB;
      localparam int ISRC = (c - row_shift(r) + NB) % NB;
      assign fwd_perm[8*(4*c+r) +: 8] = b_shift[8*(4*FSRC+r) +: 8];
      assign inv_perm[8*(4*c+r) +: 8] = b_shift[8*(4*ISRC+r) +: 8];
    end
  end

  assign perm = in_inv ? inv_perm : fwd_perm;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; ready depends only on registered occupancy, never on the far side's ready.
  logic [0:W-1]  mem_q [DEPTH];
  logic          inv_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  assign in_ready  = (level_q < LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is left unreset; the empty-FIFO masking below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]     <= perm;
      inv_mem_q[wr_ptr_q] <= in_inv;
    end
  end

  assign a_shift = out_valid ? mem_q[rd_ptr_q]     : '0;
  assign out_inv = out_valid ? inv_mem_q[rd_ptr_q] : 1'b0;
  assign level   = level_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: hand-computed vector table, NB=8 index
// vector, streaming, back-pressure and mid-stream reset sequences.
module tb_shift_rows_pipe;

  logic         clk;
  logic         rst_n;

  logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
  logic [0:127] b_shift, a_shift;
  logic [1:0]   level;

  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8;
  logic [0:255] b8, a8;
  logic [1:0]   level8;

  int checks;
  int errors;
  int pop_cnt;

  logic [0:127] drv_exp;
  logic [128:0] exp_q[$];

  shift_rows_pipe #(.NB(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .b_shift(b_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .a_shift(a_shift),
    .level(level)
  );

  shift_rows_pipe #(.NB(8), .DEPTH(2)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8), .b_shift(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_inv(out_inv8), .a_shift(a8),
    .level(level8)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A block offered without being taken must still be offered next cycle.
  assert property (@(posedge clk) disable iff (!rst_n) (in_valid && !in_ready) |=> in_valid)
    else $error("in_valid dropped without handshake");

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:255] ref_shift(input logic [0:255] x, input int nb, input logic inv);
    logic [0:255] y;
    int s8[4];
    int s, src;
    s8 = '{0, 1, 3, 4};
    y = '0;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        s = (nb == 8) ? s8[r] : r;
        src = inv ? (c - s + nb) % nb : (c + s) % nb;
        y[8*(4*c+r) +: 8] = x[8*(4*src+r) +: 8];
      end
    end
    return y;
  endfunction

  function automatic logic [0:127] ref4(input logic [0:127] x, input logic inv);
    logic [0:255] t;
    t = ref_shift({x, 128'h0}, 4, inv);
    return t[0:127];
  endfunction

  // ---------------- scoreboard ----------------
  // Inputs change just after posedge, so negedge sees the handshake of the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got %h with no expected entry", {out_inv, a_shift});
        end else begin
          chk("sb_head", {127'h0, out_inv, a_shift}, {127'h0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_inv, drv_exp});
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [0:127] din;
    logic         inv;
    logic [0:127] exp;
  } vec_t;

  vec_t vecs[5];
  logic [0:127] xs[8];
  logic [0:255] idx8;
  logic [0:255] a8_exp;
  int pops_before;

  initial begin
    vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h00050a0f04090e03080d02070c01060b};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 128'h000d0a0704010e0b0805020f0c090603};
    vecs[4] = '{{16{8'haa}},                          1'b1, {16{8'haa}}};

    checks = 0; errors = 0; pop_cnt = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_inv = 1'b0; b_shift = '0; out_ready = 1'b0; drv_exp = '0;
    in_valid8 = 1'b0; in_inv8 = 1'b0; b8 = '0; out_ready8 = 1'b1;

    // Reset state
    #12;
    chk("rst_level", 256'(level), 256'd0);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_in_ready", 256'(in_ready), 256'd1);
    chk("rst_a_shift", 256'(a_shift), 256'd0);
    step();
    rst_n = 1'b1;

    // Table-driven single blocks, one-cycle latency each
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; b_shift = vecs[i].din; in_inv = vecs[i].inv;
      drv_exp = vecs[i].exp; out_ready = 1'b1;
      chk($sformatf("v%0d_in_ready", i), 256'(in_ready), 256'd1);
      chk($sformatf("v%0d_pre_valid", i), 256'(out_valid), 256'd0);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), 256'(out_valid), 256'd1);
      chk($sformatf("v%0d_a_shift", i), 256'(a_shift), 256'(vecs[i].exp));
      chk($sformatf("v%0d_out_inv", i), 256'(out_inv), 256'(vecs[i].inv));
      chk($sformatf("v%0d_level", i), 256'(level), 256'd1);
      step();
      chk($sformatf("v%0d_drained", i), 256'(level), 256'd0);
    end

    // NB=8 forward on byte-index input
    for (int k = 0; k < 32; k++) idx8[8*k +: 8] = 8'(k);
    b8 = idx8; in_inv8 = 1'b0; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    a8_exp = ref_shift(idx8, 8, 1'b0);
    chk("nb8_valid", 256'(out_valid8), 256'd1);
    chk("nb8_r1c0", 256'(a8[8:15]), 256'd5);
    chk("nb8_r2c0", 256'(a8[16:23]), 256'd14);
    chk("nb8_r3c0", 256'(a8[24:31]), 256'd19);
    chk("nb8_full", 256'(a8), 256'(a8_exp));
    chk("nb8_inv", 256'(out_inv8), 256'd0);
    step();
    chk("nb8_drained", 256'(level8), 256'd0);

    // Streaming: x forward then forward(x) inverse, which must return x
    for (int j = 0; j < 8; j++) xs[j] = {$urandom, $urandom, $urandom, $urandom};
    pops_before = pop_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_inv   = i[0];
      b_shift  = i[0] ? ref4(xs[i/2], 1'b0) : xs[i/2];
      drv_exp  = i[0] ? xs[i/2] : ref4(xs[i/2], 1'b0);
      chk($sformatf("st%0d_in_ready", i), 256'(in_ready), 256'd1);
      if (i > 0) chk($sformatf("st%0d_no_bubble", i), 256'(out_valid), 256'd1);
      step();
    end
    in_valid = 1'b0;
    chk("st_last_valid", 256'(out_valid), 256'd1);
    step();
    chk("st_drained", 256'(level), 256'd0);
    chk("st_pop_count", 256'(pop_cnt - pops_before), 256'd16);

    // Back-pressure with DEPTH=2
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_inv = 1'(i); b_shift = vecs[2+i].din; drv_exp = vecs[2+i].exp;
      step();
    end
    in_inv = 1'b0; b_shift = vecs[0].din; drv_exp = vecs[0].exp;
    chk("bp_level_full", 256'(level), 256'd2);
    chk("bp_in_ready_low", 256'(in_ready), 256'd0);
    step();
    chk("bp_held_level", 256'(level), 256'd2);
    chk("bp_held_ready", 256'(in_ready), 256'd0);
    chk("bp_head_first", 256'(a_shift), 256'(vecs[2].exp));
    out_ready = 1'b1;
    step();
    chk("bp_pop_level", 256'(level), 256'd1);
    chk("bp_ready_back", 256'(in_ready), 256'd1);
    chk("bp_head_second", 256'(a_shift), 256'(vecs[3].exp));
    step();
    in_valid = 1'b0;
    chk("bp_push_pop_level", 256'(level), 256'd1);
    chk("bp_head_third", 256'(a_shift), 256'(vecs[0].exp));
    step();
    chk("bp_drained", 256'(level), 256'd0);

    // Mid-stream reset at level 2, checked before any clock edge
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_inv = 1'b1; b_shift = vecs[1].din; drv_exp = vecs[1].exp;
      step();
    end
    in_valid = 1'b0;
    chk("mr_level_pre", 256'(level), 256'd2);
    rst_n = 1'b0;
    #1;
    chk("mr_level", 256'(level), 256'd0);
    chk("mr_out_valid", 256'(out_valid), 256'd0);
    chk("mr_a_shift", 256'(a_shift), 256'd0);
    chk("mr_out_inv", 256'(out_inv), 256'd0);
    chk("mr_in_ready", 256'(in_ready), 256'd1);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inv = 1'b0; b_shift = vecs[0].din; drv_exp = vecs[0].exp;
    step();
    in_valid = 1'b0;
    chk("mr_post_valid", 256'(out_valid), 256'd1);
    chk("mr_post_data", 256'(a_shift), 256'(vecs[0].exp));
    step();
    step();
    chk("sb_empty", 256'(exp_q.size()), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
